// File: rtl/lsu_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
// master = pipeline + memory side, slave = the LSU itself.
`include "constants.vh"

interface lsu_if #(parameter int XLEN = `XLEN);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_misalign;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_write_data;
    logic [XLEN-1:0] mem_read_data;
    logic            write_en;
    logic            mem_en;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misalign,
               mem_addr, mem_write_data, write_en, mem_en
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_misalign,
               mem_addr, mem_write_data, write_en, mem_en
    );
endinterface

// File: rtl/constants.vh
// Shared architectural constants for the core datapath.
`ifndef CONSTANTS_VH
`define CONSTANTS_VH
`define XLEN 32
`endif

// File: rtl/lsu.sv
// Load/store unit: one access at a time, sub-word stores as read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses respond with rsp_misalign instead of aligning.
`include "constants.vh"

module lsu #(
    parameter int MEM_WORDS = 2048
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);
    localparam int XLEN      = `XLEN;
    localparam int NUM_LANES = XLEN / 8;
    localparam int LW        = $clog2(NUM_LANES);

    typedef enum logic [2:0] {
        IDLE, RD, WR, RESP
`ifdef LSU_MISALIGN_TRAP_EN
        , ERR
`endif
    } state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    typedef struct packed {
        logic            we;
        size_t           size;
        logic            uns;
        logic [LW-1:0]   lane;
        logic [XLEN-1:0] widx;
        logic [XLEN-1:0] wdata;
    } req_t;

    state_t          r_state, w_next;
    req_t            r_req, w_req;
    logic [XLEN-1:0] r_wword;
    logic [XLEN-1:0] r_rdata;
    logic            r_misalign;

    // Request decode: undefined widths fall into W, the funct3[2] bit only matters for loads
    always_comb begin
        w_req       = '0;
        w_req.we    = bus.req_we;
        w_req.uns   = bus.req_funct3[2];
        w_req.wdata = bus.req_wdata;
        w_req.widx  = (bus.req_addr >> 2) % XLEN'(MEM_WORDS);
        case (bus.req_funct3[1:0])
            2'b00:   w_req.size = SZ_B;
            2'b01:   w_req.size = SZ_H;
            default: w_req.size = SZ_W;
        endcase
        case (w_req.size)
            SZ_B:    w_req.lane = bus.req_addr[LW-1:0];
            SZ_H:    w_req.lane = {bus.req_addr[LW-1:1], 1'b0};
            default: w_req.lane = '0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_mis;
    assign w_mis = (w_req.size == SZ_H && bus.req_addr[0]) ||
                   (w_req.size == SZ_W && |bus.req_addr[LW-1:0]);
`endif

    // Store merge: replicate store data across lanes, then pick per byte lane
    logic [NUM_LANES-1:0][7:0] w_rd_b, w_rep_b, w_merge;
    logic [NUM_LANES-1:0]      w_bsel;

    assign w_rd_b  = bus.mem_read_data;
    assign w_rep_b = (r_req.size == SZ_B) ? {NUM_LANES{r_req.wdata[7:0]}} :
                     (r_req.size == SZ_H) ? {(NUM_LANES/2){r_req.wdata[15:0]}} : r_req.wdata;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign w_bsel[g]  = (r_req.size == SZ_B) ? (r_req.lane == LW'(g)) :
                            (r_req.size == SZ_H) ? (r_req.lane[LW-1:1] == (LW-1)'(g / 2)) : 1'b1;
        assign w_merge[g] = w_bsel[g] ? w_rep_b[g] : w_rd_b[g];
    end

    // Load extract: shift selected lane down, then extend
    logic [XLEN-1:0] w_sh, w_ld;
    assign w_sh = bus.mem_read_data >> {r_req.lane, 3'b000};
    always_comb begin
        case (r_req.size)
            SZ_B:    w_ld = {{(XLEN-8){~r_req.uns & w_sh[7]}}, w_sh[7:0]};
            SZ_H:    w_ld = {{(XLEN-16){~r_req.uns & w_sh[15]}}, w_sh[15:0]};
            default: w_ld = w_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.req_valid) begin
                if (bus.req_we && w_req.size == SZ_W) w_next = WR;
                else                                  w_next = RD;
`ifdef LSU_MISALIGN_TRAP_EN
                if (w_mis) w_next = ERR;
`endif
            end
            RD:   w_next = r_req.we ? WR : RESP;
            WR:   w_next = RESP;
            RESP: if (bus.rsp_ready) w_next = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
            ERR:  w_next = RESP;
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req      <= '0;
            r_wword    <= '0;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_req   <= w_req;
                    r_wword <= bus.req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                    r_misalign <= w_mis;
                    if (w_mis) r_rdata <= '0;
`endif
                end
                RD: begin
                    if (r_req.we) r_wword <= w_merge;
                    else          r_rdata <= w_ld;
                end
                WR:      r_rdata <= '0;
                default: ;
            endcase
        end
    end

    // write_en is purely state-decoded so an asynchronous reset kills it at once
    assign bus.req_ready      = (r_state == IDLE);
    assign bus.rsp_valid      = (r_state == RESP);
    assign bus.rsp_rdata      = r_rdata;
    assign bus.mem_en         = (r_state == RD) || (r_state == WR);
    assign bus.write_en       = (r_state == WR);
    assign bus.mem_addr       = (r_state == IDLE) ? '0 : r_req.widx;
    assign bus.mem_write_data = (r_state == IDLE) ? '0 : r_wword;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.rsp_misalign   = r_misalign;
`else
    assign bus.rsp_misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: behavioural word memory plus hand-computed expectations.
module tb_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if bus();
    lsu #(.MEM_WORDS(2048)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] mem [0:2047];
    assign bus.mem_read_data = mem[bus.mem_addr[10:0]];
    always @(posedge clk) if (bus.write_en) mem[bus.mem_addr[10:0]] = bus.mem_write_data;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    logic [31:0] t_rdata, t_wa, t_wd, t_ra;
    logic        t_mis;
    int          t_lat, t_wens, t_mens;

    // One full transaction; t_lat counts cycles from the accept cycle to first rsp_valid
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        t_lat = 1; t_wens = 0; t_mens = 0; t_wa = '0; t_wd = '0; t_ra = '0;
        while (!bus.rsp_valid && t_lat < 20) begin
            if (bus.mem_en)   begin t_mens++; t_ra = bus.mem_addr; end
            if (bus.write_en) begin t_wens++; t_wa = bus.mem_addr; t_wd = bus.mem_write_data; end
            @(posedge clk); #1;
            t_lat++;
        end
        if (!bus.rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
        t_rdata = bus.rsp_rdata;
        t_mis   = bus.rsp_misalign;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_rdata", bus.rsp_rdata, t_rdata);
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("back_idle", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_misalign", 32'(bus.rsp_misalign), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_write_en", 32'(bus.write_en), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_write_data, 32'd0);

        // LB / LBU from byte lane 2 of word 5
        mem[5] = 32'h8081_7F02;
        xact(1'b0, 3'b000, 32'h16, 32'h0, 0);
        chk("lb_lat", 32'(t_lat), 32'd2);
        chk("lb_data", t_rdata, 32'hFFFF_FF81);
        chk("lb_mens", 32'(t_mens), 32'd1);
        chk("lb_wens", 32'(t_wens), 32'd0);
        chk("lb_addr", t_ra, 32'd5);
        xact(1'b0, 3'b100, 32'h16, 32'h0, 0);
        chk("lbu_data", t_rdata, 32'h0000_0081);

        // SB as read-modify-write into lane 1
        mem[5] = 32'h1122_3344;
        xact(1'b1, 3'b000, 32'h15, 32'hFFFF_FFAB, 0);
        chk("sb_lat", 32'(t_lat), 32'd3);
        chk("sb_wens", 32'(t_wens), 32'd1);
        chk("sb_mens", 32'(t_mens), 32'd2);
        chk("sb_mem", mem[5], 32'h1122_AB44);
        chk("sb_rdata", t_rdata, 32'd0);

        // SW then LW back
        xact(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 0);
        chk("sw_lat", 32'(t_lat), 32'd2);
        chk("sw_wens", 32'(t_wens), 32'd1);
        chk("sw_waddr", t_wa, 32'd8);
        chk("sw_wdata", t_wd, 32'hDEAD_BEEF);
        xact(1'b0, 3'b010, 32'h20, 32'h0, 0);
        chk("lw_data", t_rdata, 32'hDEAD_BEEF);

        // LH with consumer stall, then LHU of the low half
        mem[4] = 32'h9ABC_1234;
        xact(1'b0, 3'b001, 32'h12, 32'h0, 4);
        chk("lh_data", t_rdata, 32'hFFFF_9ABC);
        xact(1'b0, 3'b101, 32'h10, 32'h0, 0);
        chk("lhu_data", t_rdata, 32'h0000_1234);

        // SH upper half, only wdata[15:0] lands
        xact(1'b1, 3'b001, 32'h12, 32'hFFFF_5566, 0);
        chk("sh_mem", mem[4], 32'h5566_1234);

        // Misaligned LW / LH
        xact(1'b0, 3'b010, 32'h22, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_lw_flag", 32'(t_mis), 32'd1);
        chk("mis_lw_data", t_rdata, 32'd0);
        chk("mis_lw_mens", 32'(t_mens), 32'd0);
`else
        chk("mis_lw_flag", 32'(t_mis), 32'd0);
        chk("mis_lw_data", t_rdata, 32'hDEAD_BEEF);
`endif
        xact(1'b0, 3'b001, 32'h13, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_lh_flag", 32'(t_mis), 32'd1);
        chk("mis_lh_data", t_rdata, 32'd0);
`else
        chk("mis_lh_data", t_rdata, 32'h0000_5566);
`endif

        // Undefined funct3 loads as W; store BU acts as SB
        xact(1'b0, 3'b011, 32'h20, 32'h0, 0);
        chk("f3_011_data", t_rdata, 32'hDEAD_BEEF);
        xact(1'b1, 3'b100, 32'h21, 32'h0000_0077, 0);
        chk("sbu_mem", mem[8], 32'hDEAD_77EF);

        // Word index wraps modulo MEM_WORDS
        mem[3] = 32'h1357_2468;
        xact(1'b0, 3'b010, 32'h200C, 32'h0, 0);
        chk("wrap_addr", t_ra, 32'd3);
        chk("wrap_data", t_rdata, 32'h1357_2468);

        // Reset asserted in the WR cycle of an SB aborts the write
        mem[6] = 32'hCAFE_F00D;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h19; bus.req_wdata = 32'h11;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstwr_we_before", 32'(bus.write_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstwr_we_after", 32'(bus.write_en), 32'd0);
        chk("rstwr_mem_en", 32'(bus.mem_en), 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rstwr_mem", mem[6], 32'hCAFE_F00D);
        chk("rstwr_ready", 32'(bus.req_ready), 32'd1);
        chk("rstwr_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstwr_mem_addr", bus.mem_addr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: MEM_WORDS, 2048, depth of the word-addressed data memory; word index wraps modulo MEM_WORDS.
REQ-002 The block SHALL take XLEN from constants.vh (`XLEN); all data/address buses below are XLEN wide.
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 rst_n  in  1  reset is asynchronous and active-low.
REQ-005 req_valid  in  1  pipeline access request.
REQ-006 req_ready  out  1  LSU can accept a request (IDLE only).
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  XLEN  byte address.
REQ-010 req_wdata  in  XLEN  store data, right-aligned.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  consumer takes response.
REQ-013 rsp_rdata  out  XLEN  load result, extended; 0 for stores.
REQ-014 rsp_misalign  out  1  access was misaligned (see Configuration).
REQ-015 mem_addr  out  XLEN  word index = req_addr[XLEN-1:2] mod MEM_WORDS.
REQ-016 mem_write_data  out  XLEN  full word to write.
REQ-017 mem_read_data  in  XLEN  combinational read word of current mem_addr.
REQ-018 write_en  out  1  memory write strobe, written at next posedge.
REQ-019 mem_en  out  1  memory access active.

Function
REQ-020 FSM states SHALL be IDLE, RD, WR, RESP, ERR; req_ready=1 only in IDLE.
REQ-021 Request accepted when req_valid&req_ready; addr, we, funct3, wdata SHALL be latched that cycle.
REQ-022 Load: IDLE->RD->RESP; RD drives mem_en=1, write_en=0, captures mem_read_data; rsp_valid asserts 2 cycles after accept.
REQ-023 Store W: IDLE->WR->RESP; WR drives mem_en=1, write_en=1, mem_write_data=wdata.
REQ-024 Store B/H: IDLE->RD->WR->RESP (read-modify-write, memory has no byte enables); WR word = captured word with selected byte/halfword lane replaced by wdata[7:0]/[15:0].
REQ-025 Lane selection: byte lane = addr[1:0], halfword lane = addr[1]; little-endian.
REQ-026 Load extension: B/H sign-extend, BU/HU zero-extend, W passthrough.
REQ-027 mem_en, write_en SHALL be 0 in IDLE, RESP, ERR; mem_addr/mem_write_data hold latched values otherwise 0 in IDLE.
REQ-028 RESP: rsp_valid=1 held, rsp_rdata stable, until rsp_ready; then ->IDLE; same-cycle new request not accepted (req_ready=0 in RESP).
REQ-029 Undefined funct3 (011,110,111) SHALL be treated as W.
REQ-030 Store to funct3 BU/HU SHALL be treated as B/H.

Reset
REQ-031 On rst_n low, FSM SHALL go to IDLE immediately, aborting any access; write_en drops asynchronously, no partial write completes.
REQ-032 Reset values: req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_misalign=0, mem_en=0, write_en=0, mem_addr=0, mem_write_data=0.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: H access with addr[0]=1 or W with addr[1:0]!=0 SHALL go IDLE->ERR->RESP with rsp_misalign=1, rsp_rdata=0, no memory access (mem_en never asserted).
REQ-034 Macro undefined: ERR state absent, misaligned low address bits SHALL be forced to natural alignment, access proceeds normally, rsp_misalign tied 0.

Verification
REQ-035 Mem word 5 = 0x8081_7F02; LB addr 0x16 -> rsp_rdata 0xFFFF_FF81 two cycles after accept; LBU -> 0x0000_0081.
REQ-036 Word 5 = 0x1122_3344; SB addr 0x15 wdata 0xAB -> one RD, one write_en pulse, word 5 = 0x1122_AB44, rsp_valid 3 cycles after accept.
REQ-037 SW addr 0x20 wdata 0xDEAD_BEEF -> write_en=1 one cycle with mem_addr=8; then LW 0x20 returns 0xDEAD_BEEF.
REQ-038 rsp_ready held 0 for 4 cycles after LH -> rsp_valid/rsp_rdata stable, req_ready=0 throughout.
REQ-039 With LSU_MISALIGN_TRAP_EN: LW addr 0x22 -> rsp_misalign=1, rsp_rdata=0, mem_en never 1; without: returns word 8.
REQ-040 rst_n asserted during WR of SB -> write_en 0 immediately, target word unchanged, after release req_ready=1, rsp_valid=0.
